aes_shift_rows: RTL and testbench
=================================

# aes_shift_rows

Streaming Rijndael ShiftRows / InvShiftRows unit for a state of `NB` 32-bit columns (block sizes of 128, 192 and 256 bits).
- Row `r` of the state is rotated by a per-row byte offset selected from `NB`, in the direction set by a per-beat mode bit.
- The rotated state passes through a `LAT`-deep valid/ready register pipeline with full backpressure.
- It sits between SubBytes and MixColumns in the round datapath. It supersedes the single-word fixed-offset rotator.

## Interface
Parameters:
- `NB`, 4, number of state columns; legal values 4, 6, 8 (elaboration error otherwise).
- `LAT`, 1, pipeline register stages; legal values 1..4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all pipeline stages.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  unit can accept a beat this cycle.
- `in_data`  in  32*NB  input state.
- `in_inv`  in  1  0 = ShiftRows, 1 = InvShiftRows.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  32*NB  rotated state.
- `out_inv`  out  1  mode bit carried with the beat.

## Operation
- State layout is column-major. Byte index `k = r + 4c`, with rows `r` 0..3 and columns `c` 0..NB-1. Byte `k` occupies `in_data[8*(4*NB-1-k) +: 8]`, so byte 0 is the MSB byte.
- Row offsets `off(r)` for rows 0..3:
  - NB=4: 0,1,2,3.
  - NB=6: 0,1,2,3.
  - NB=8: 0,1,3,4.
- Forward mode (`in_inv=0`): `s'[r][c] = s[r][(c + off(r)) mod NB]`.
- Inverse mode (`in_inv=1`): `s'[r][c] = s[r][(c - off(r) + NB) mod NB]`. The modulo uses NB-range arithmetic and never a power-of-two wrap.
- Rotation is combinational ahead of stage 1. Stages 2..LAT are pure registers for data, mode and valid.
- Stage `i` loads when it is empty or stage `i+1` is loading. The last stage loads when it is empty or `out_ready=1`.
- `in_ready` equals the stage-1 load condition. A beat transfers when `in_valid && in_ready`.
- `out_valid`, `out_data` and `out_inv` come directly from the last stage's registers.
- Data and mode registers load only on a transfer into that stage. Otherwise they hold.
- `flush=1`:
  - Clears every stage valid at the next edge.
  - A beat offered in the same cycle is dropped.
  - `in_ready` still reads as computed.
  - Data registers are not cleared.
- Reset (`rst_n=0`, at any time, including mid-stream):
  - All stage valids go to 0 and all data/mode registers go to 0.
  - `out_valid=0`, `out_data=0`, `out_inv=0`.
  - `in_ready=1` once reset is released.
  - Beats in flight are lost.

## Timing
- Latency: a beat accepted at edge `n` shows `out_valid=1` after edge `n+LAT-1`. It is available for capture at edge `n+LAT` when the pipe is not stalled.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- `out_ready` to `in_ready` is a combinational path through the stage load chain. This is accepted; no skid buffer.
- `out_valid` must not drop while `out_ready=0`. `out_data` and `out_inv` must stay stable under stall.
- Simultaneous events:
  - Accept while the last stage drains is legal; the pipe stays full.
  - `flush` together with `out_ready=1` means the current output beat is consumed, then all stages go empty.
- Back-to-back beats may alternate `in_inv`. Each beat's mode travels with it.

## Structure
- Shared package `aes_pkg`:
  - Row-offset function `shift_off(nb, r)`.
  - State-width constant `32*NB`.
  - Byte index helper `k = r + 4c`.
  - Reused by MixColumns and the key schedule.
- Sub-module `aes_row_rot`:
  - Combinational, parametrised by `NB`.
  - Inputs: one row of NB bytes, rotate amount 0..NB-1, direction. Output: the rotated row.
  - Instantiated 4 times; row 0 has amount 0 and is optimised out.
- Top level holds the stage registers and the handshake chain.

## Test plan
- NB=4, LAT=1, forward, `in_data=128'h000102030405060708090a0b0c0d0e0f` → `out_data=128'h00050a0f04090e03080d02070c01060b`, `out_valid` one cycle after accept.
- Same input with `in_inv=1` → `128'h000d0a0704010e0b0805020f0c090603`. Then feed the forward result back with `in_inv=1` → original input returned.
- NB=8, forward, byte `k` = `k` for all bytes:
  - Row 3 output column 0 is input byte `3+4*4` = 8'h13.
  - Row 2 output column 7 is input byte `2+4*2` = 8'h0a (wrap across NB=8).
- NB=6, LAT=3, random states, random `in_inv`, random `out_ready` stall patterns versus a reference model:
  - No beat lost, duplicated or reordered.
  - Outputs stable under stall.
  - Full throughput when `out_ready=1`.
- Pipe full, `out_ready=0`, `in_valid=1` → `in_ready=0`. Then assert `flush` for one cycle → `out_valid=0` next cycle and the pending input beat is dropped.
- Drop `rst_n` mid-stream with LAT=4 full → all outputs 0 asynchronously. After release `in_ready=1`, and the first new beat emerges after 4 edges.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: ShiftRows row offsets, state width and byte indexing.
// Used by ShiftRows, MixColumns and the key schedule.
package aes_pkg;

  // Byte offset for row r of a state with nb columns (nb = 4, 6 or 8).
  // For nb = 8, rows 2 and 3 shift one byte further than their row number.
  function automatic int shift_off(input int nb, input int r);
    if (nb == 8 && r >= 2) begin
      return r + 1;
    end
    return r;
  endfunction

  // State width in bits for nb 32-bit columns.
  function automatic int state_w(input int nb);
    return 32 * nb;
  endfunction

  // Column-major byte index: row r, column c.
  function automatic int byte_idx(input int r, input int c);
    return r + 4 * c;
  endfunction

endpackage

// File: rtl/aes_row_rot.sv
// One state row of NB bytes rotated by amt columns, left (forward ShiftRows)
// or right (InvShiftRows). Column c sits at row[8*(NB-1-c) +: 8].
module aes_row_rot #(
  parameter int NB = 4
) (
  input  logic [8*NB-1:0]         row,
  input  logic [$clog2(NB)-1:0]   amt,
  input  logic                    inv,
  output logic [8*NB-1:0]         rot
);

  // Pick each output column's source column with mod-NB wrap (NB may be 6).
  always_comb begin
    int src;
    rot = '0;
    src = 0;
    for (int c = 0; c < NB; c++) begin
      if (inv) begin
        src = (c + NB - int'(amt)) % NB;
      end else begin
        src = (c + int'(amt)) % NB;
      end
      rot[8*(NB-1-c) +: 8] = row[8*(NB-1-src) +: 8];
    end
  end

endmodule

// File: rtl/aes_shift_rows.sv
// Streaming ShiftRows / InvShiftRows for an NB-column state, followed by a
// LAT-deep valid/ready register pipeline with full backpressure.
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are 1. A stage loads when it is empty or the stage after it
// is loading (the last stage: when empty or out_ready=1), so in_ready is
// combinational from out_ready. Valid never drops and data/mode stay stable
// while the consumer holds ready low. flush empties every stage at the next
// edge; a beat offered alongside it is discarded.
module aes_shift_rows
  import aes_pkg::*;
#(
  parameter int NB  = 4,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic             out_inv
);

  localparam int W  = state_w(NB);
  localparam int AW = $clog2(NB);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("aes_shift_rows: NB must be 4, 6 or 8");
  end
  if (LAT < 1 || LAT > 4) begin : g_lat_check
    $error("aes_shift_rows: LAT must be 1..4");
  end

  logic [8*NB-1:0] row_in  [4];
  logic [8*NB-1:0] row_out [4];
  logic [W-1:0]    rot_state;

  // Split the column-major input into four rows, and reassemble the result.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = '0;
    end
    rot_state = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        row_in[r][8*(NB-1-c) +: 8] = in_data[8*(4*NB-1-byte_idx(r, c)) +: 8];
        rot_state[8*(4*NB-1-byte_idx(r, c)) +: 8] = row_out[r][8*(NB-1-c) +: 8];
      end
    end
  end

  // Row 0 has a zero offset, so its rotator collapses to wires.
  for (genvar r = 0; r < 4; r++) begin : g_row
    aes_row_rot #(.NB(NB)) u_rot (
      .row (row_in[r]),
      .amt (AW'(shift_off(NB, r))),
      .inv (in_inv),
      .rot (row_out[r])
    );
  end

  logic [LAT-1:0] vld;
  logic [LAT-1:0] inv_q;
  logic [W-1:0]   dat   [LAT];
  logic [LAT-1:0] load;
  logic [LAT-1:0] src_v;
  logic [LAT-1:0] src_i;
  logic [W-1:0]   src_d [LAT];

  // Load chain: stage i loads if any stage from i to the end is empty, or
  // the consumer is taking the last beat.
  always_comb begin
    logic chain;
    chain = out_ready;
    load  = '0;
    for (int i = LAT - 1; i >= 0; i--) begin
      chain   = chain || !vld[i];
      load[i] = chain;
    end
  end

  // What each stage would capture: the rotated input for stage 0, the
  // previous stage's registers otherwise.
  always_comb begin
    src_v = '0;
    src_i = '0;
    for (int i = 0; i < LAT; i++) begin
      src_d[i] = '0;
    end
    src_v[0] = in_valid;
    src_i[0] = in_inv;
    src_d[0] = rot_state;
    for (int i = 1; i < LAT; i++) begin
      src_v[i] = vld[i-1];
      src_i[i] = inv_q[i-1];
      src_d[i] = dat[i-1];
    end
  end

  // Stage valids follow the load chain; data and mode capture only on a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      inv_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (flush) begin
          vld[i] <= 1'b0;
        end else if (load[i]) begin
          vld[i] <= src_v[i];
        end
        if (load[i] && src_v[i]) begin
          dat[i]   <= src_d[i];
          inv_q[i] <= src_i[i];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];
  assign out_inv   = inv_q[LAT-1];

endmodule

// File: tb/tb_aes_shift_rows.sv
// Bench for aes_shift_rows: three instances (NB=4/LAT=1, NB=6/LAT=3,
// NB=8/LAT=4), each with an expected-beat queue filled by its driver and
// drained by its own output monitor.
module tb_aes_shift_rows;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         f4 = 1'b0, v4 = 1'b0, i4 = 1'b0, or4 = 1'b1;
  logic         r4, ov4, oi4;
  logic [127:0] d4 = '0, od4;

  logic         f6 = 1'b0, v6 = 1'b0, i6 = 1'b0, or6 = 1'b1;
  logic         r6, ov6, oi6;
  logic [191:0] d6 = '0, od6;

  logic         f8 = 1'b0, v8 = 1'b0, i8 = 1'b0, or8 = 1'b1;
  logic         r8, ov8, oi8;
  logic [255:0] d8 = '0, od8;

  aes_shift_rows #(.NB(4), .LAT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(f4), .in_valid(v4), .in_ready(r4),
    .in_data(d4), .in_inv(i4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .out_inv(oi4));

  aes_shift_rows #(.NB(6), .LAT(3)) u6 (
    .clk(clk), .rst_n(rst_n), .flush(f6), .in_valid(v6), .in_ready(r6),
    .in_data(d6), .in_inv(i6), .out_valid(ov6), .out_ready(or6),
    .out_data(od6), .out_inv(oi6));

  aes_shift_rows #(.NB(8), .LAT(4)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(f8), .in_valid(v8), .in_ready(r8),
    .in_data(d8), .in_inv(i8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .out_inv(oi8));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [256:0] exp_q4[$];
  logic [256:0] exp_q6[$];
  logic [256:0] exp_q8[$];

  task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [256:0] pk(input logic inv, input logic [255:0] d);
    return {inv, d};
  endfunction

  // Reference: state as a 4 x nb byte grid, row r rotated by its offset.
  function automatic logic [255:0] ref_shift(input logic [255:0] d, input int nb, input logic inv);
    logic [7:0]   s [4][8];
    logic [255:0] o;
    int off, src;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++)
        s[r][c] = d[8*(4*nb-1-(r+4*c)) +: 8];
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - off + nb) % nb : (c + off) % nb;
        o[8*(4*nb-1-(r+4*c)) +: 8] = s[r][src];
      end
    end
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[32*i +: 32] = $urandom;
    return x;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [256:0] e;
    if (rst_n && ov4 && or4) begin
      check("u4 beat expected", 257'(exp_q4.size() != 0), 257'd1);
      if (exp_q4.size() != 0) begin
        e = exp_q4.pop_front();
        check("u4 out", pk(oi4, 256'(od4)), e);
      end
    end
  end

  always @(negedge clk) begin
    logic [256:0] e;
    if (rst_n && ov8 && or8) begin
      check("u8 beat expected", 257'(exp_q8.size() != 0), 257'd1);
      if (exp_q8.size() != 0) begin
        e = exp_q8.pop_front();
        check("u8 out", pk(oi8, od8), e);
      end
    end
  end

  logic         stall6 = 1'b0;
  logic [256:0] hold6  = '0;
  always @(negedge clk) begin
    logic [256:0] e;
    if (!rst_n) begin
      stall6 = 1'b0;
    end else begin
      if (stall6) begin
        check("u6 valid held", 257'(ov6), 257'd1);
        check("u6 data held", pk(oi6, 256'(od6)), hold6);
      end
      stall6 = ov6 && !or6 && !f6;
      hold6  = pk(oi6, 256'(od6));
      if (ov6 && or6) begin
        check("u6 beat expected", 257'(exp_q6.size() != 0), 257'd1);
        if (exp_q6.size() != 0) begin
          e = exp_q6.pop_front();
          check("u6 out", pk(oi6, 256'(od6)), e);
        end
      end
    end
  end

  // Random out_ready for u6 while enabled.
  logic rnd6 = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd6) or6 = ($urandom_range(0, 3) != 0);
  end

  // ---------------- drivers ----------------
  task automatic send4(input logic [127:0] d, input logic inv, input logic [256:0] exp);
    int t = 0;
    v4 = 1'b1; d4 = d; i4 = inv;
    @(negedge clk);
    while (!r4 && t < 100) begin @(negedge clk); t++; end
    if (r4) exp_q4.push_back(exp); else timeout("u4 accept");
    @(posedge clk); #1;
    v4 = 1'b0;
  endtask

  task automatic send6(input logic [191:0] d, input logic inv, output int waited);
    waited = 0;
    v6 = 1'b1; d6 = d; i6 = inv;
    @(negedge clk);
    while (!r6 && waited < 200) begin @(negedge clk); waited++; end
    if (r6) exp_q6.push_back(pk(inv, ref_shift(256'(d), 6, inv)));
    else timeout("u6 accept");
    @(posedge clk); #1;
    v6 = 1'b0;
  endtask

  task automatic send8(input logic [255:0] d, input logic inv);
    int t = 0;
    v8 = 1'b1; d8 = d; i8 = inv;
    @(negedge clk);
    while (!r8 && t < 100) begin @(negedge clk); t++; end
    if (r8) exp_q8.push_back(pk(inv, ref_shift(d, 8, inv)));
    else timeout("u8 accept");
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, t, edges;
    logic inv;
    logic [255:0] r, kvec;
    logic [127:0] src4, fwd4, inv4;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset u4 out_valid", 257'(ov4), 257'd0);
    check("reset u4 out_data", 257'(od4), 257'd0);
    check("reset u6 out_valid", 257'(ov6), 257'd0);
    check("reset u8 out_data", 257'(od8), 257'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("u4 in_ready after reset", 257'(r4), 257'd1);
    check("u6 in_ready after reset", 257'(r6), 257'd1);
    check("u8 in_ready after reset", 257'(r8), 257'd1);

    // NB=4 directed vectors
    src4 = 128'h000102030405060708090a0b0c0d0e0f;
    fwd4 = 128'h00050a0f04090e03080d02070c01060b;
    inv4 = 128'h000d0a0704010e0b0805020f0c090603;
    send4(src4, 1'b0, pk(1'b0, 256'(fwd4)));
    @(negedge clk);
    check("u4 latency out_valid", 257'(ov4), 257'd1);
    @(posedge clk); #1;
    send4(src4, 1'b1, pk(1'b1, 256'(inv4)));
    send4(fwd4, 1'b1, pk(1'b1, 256'(src4)));
    for (int n = 0; n < 20; n++) begin
      r = rnd256();
      inv = 1'($urandom_range(0, 1));
      send4(r[127:0], inv, pk(inv, ref_shift(256'(r[127:0]), 4, inv)));
    end

    // NB=8 byte k = k, forward
    for (int k = 0; k < 32; k++) kvec[8*(31-k) +: 8] = 8'(k);
    send8(kvec, 1'b0);
    t = 0;
    @(negedge clk);
    while (!ov8 && t < 20) begin @(negedge clk); t++; end
    if (!ov8) timeout("u8 directed out_valid");
    check("u8 row3 col0", 257'(od8[8*(31-3) +: 8]), 257'h13);
    check("u8 row2 col7", 257'(od8[8*(31-30) +: 8]), 257'h0a);
    @(posedge clk); #1;
    for (int n = 0; n < 16; n++) send8(rnd256(), 1'($urandom_range(0, 1)));

    // NB=6 random beats with random stalls
    rnd6 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      r = rnd256();
      send6(r[191:0], 1'($urandom_range(0, 1)), w);
    end
    rnd6 = 1'b0;
    or6  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      r = rnd256();
      send6(r[191:0], 1'($urandom_range(0, 1)), w);
      check("u6 full throughput", 257'(w), 257'd0);
    end
    t = 0;
    while (exp_q6.size() != 0 && t < 50) begin @(posedge clk); t++; end
    #1;
    check("u6 drained", 257'(exp_q6.size()), 257'd0);

    // NB=6 flush with a full, stalled pipe
    or6 = 1'b0;
    for (int n = 0; n < 3; n++) begin
      r = rnd256();
      send6(r[191:0], 1'b0, w);
    end
    v6 = 1'b1; d6 = '1; i6 = 1'b0;
    @(negedge clk);
    check("u6 full in_ready", 257'(r6), 257'd0);
    check("u6 full out_valid", 257'(ov6), 257'd1);
    @(posedge clk); #1;
    f6 = 1'b1;
    @(posedge clk); #1;
    f6 = 1'b0; v6 = 1'b0; or6 = 1'b1;
    exp_q6.delete();
    @(negedge clk);
    check("u6 flush out_valid", 257'(ov6), 257'd0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("u6 flushed beat dropped", 257'(ov6), 257'd0);
    end
    @(posedge clk); #1;

    // NB=8 LAT=4 reset mid-stream
    or8 = 1'b0;
    for (int n = 0; n < 4; n++) send8(rnd256(), 1'($urandom_range(0, 1)));
    v8 = 1'b1; d8 = rnd256(); i8 = 1'b1;
    @(negedge clk);
    check("u8 full in_ready", 257'(r8), 257'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("u8 async reset out_valid", 257'(ov8), 257'd0);
    check("u8 async reset out_data", 257'(od8), 257'd0);
    check("u8 async reset out_inv", 257'(oi8), 257'd0);
    exp_q8.delete();
    v8 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("u8 in_ready after reset", 257'(r8), 257'd1);
    or8 = 1'b1;
    send8(rnd256(), 1'b0);
    edges = 1;
    @(negedge clk);
    while (!ov8 && edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    check("u8 latency after reset", 257'(edges), 257'd4);

    // nothing lost
    repeat (10) @(posedge clk);
    #1;
    check("u4 queue empty", 257'(exp_q4.size()), 257'd0);
    check("u6 queue empty", 257'(exp_q6.size()), 257'd0);
    check("u8 queue empty", 257'(exp_q8.size()), 257'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
